// File: rtl/axil_bram_arbiter.sv
// rtl/axil_bram_arbiter.sv - round-robin AXI-Lite arbiter with response timeout
//
// Purpose: shares one AXI-Lite slave port between NM masters. Only one transaction
// is in flight at a time. A response timeout returns a local SLVERR so a hung slave
// cannot lock out the masters.
// Ports:
//   sclk, reset            clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*        per-master write channels, master i owns slice i
//   s_ar*/s_r*             per-master read channels, master i owns slice i
//   m_aw*/m_w*/m_b*        write channels towards the shared slave
//   m_ar*/m_r*             read channels towards the shared slave
//   grant                  one-hot owner of the current transaction
//   busy                   high whenever a transaction is being arbitrated/served
//   timeout_cnt            saturating count of locally generated timeout responses
module axil_bram_arbiter #(
  parameter int              NM      = 2,
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              TIMEOUT = 1024,
  parameter logic [DW-1:0]   ERRDATA = DW'(32'hDEADBEEF)
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic [NM*AW-1:0]     s_awaddr,
  input  logic [NM-1:0]        s_awvalid,
  output logic [NM-1:0]        s_awready,
  input  logic [NM*DW-1:0]     s_wdata,
  input  logic [NM*DW/8-1:0]   s_wstrb,
  input  logic [NM-1:0]        s_wvalid,
  output logic [NM-1:0]        s_wready,
  output logic [NM*2-1:0]      s_bresp,
  output logic [NM-1:0]        s_bvalid,
  input  logic [NM-1:0]        s_bready,
  input  logic [NM*AW-1:0]     s_araddr,
  input  logic [NM-1:0]        s_arvalid,
  output logic [NM-1:0]        s_arready,
  output logic [NM*DW-1:0]     s_rdata,
  output logic [NM*2-1:0]      s_rresp,
  output logic [NM-1:0]        s_rvalid,
  input  logic [NM-1:0]        s_rready,
  output logic [AW-1:0]        m_awaddr,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [DW-1:0]        m_wdata,
  output logic [DW/8-1:0]      m_wstrb,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic [AW-1:0]        m_araddr,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [DW-1:0]        m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic [NM-1:0]        grant,
  output logic                 busy,
  output logic [15:0]          timeout_cnt
);

  localparam int          PW     = (NM > 2) ? 2 : 1;
  localparam int          SW     = DW / 8;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [31:0]     tcnt_q, tcnt_d;
  logic [15:0]     tocnt_q, tocnt_d;

  logic [NM-1:0]   wreq, rreq;
  logic            arb_found, arb_wr;
  logic [PW-1:0]   arb_idx, arb_scan, rr_next;
  logic [PW:0]     arb_sum;
  logic            err_pend, aw_hs, w_hs;

  assign wreq = s_awvalid & s_wvalid;
  assign rreq = s_arvalid;

  // The counter parks at TO_LIM, so equality marks a pending local error response.
  assign err_pend = (TO_LIM != 32'd0) && (tcnt_q == TO_LIM);
  assign rr_next  = (gidx_q == PW'(NM - 1)) ? '0 : gidx_q + 1'b1;

  // Straight-through address/data from whichever master was last granted.
  assign m_awaddr = s_awaddr[gidx_q*AW +: AW];
  assign m_wdata  = s_wdata[gidx_q*DW +: DW];
  assign m_wstrb  = s_wstrb[gidx_q*SW +: SW];
  assign m_araddr = s_araddr[gidx_q*AW +: AW];

  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_cnt = tocnt_q;

  // Cyclic scan starting at rr_ptr; the first requester found wins.
  always_comb begin
    arb_found = 1'b0;
    arb_wr    = 1'b0;
    arb_idx   = '0;
    arb_scan  = '0;
    arb_sum   = '0;
    for (int k = 0; k < NM; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (arb_sum >= (PW+1)'(NM)) arb_sum = arb_sum - (PW+1)'(NM);
      arb_scan = arb_sum[PW-1:0];
      if (!arb_found && (wreq[arb_scan] || rreq[arb_scan])) begin
        arb_found = 1'b1;
        arb_idx   = arb_scan;
        arb_wr    = wreq[arb_scan];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    tcnt_d    = tcnt_q;
    tocnt_d   = tocnt_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bresp   = '0;
    s_bvalid  = '0;
    s_arready = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Drain any stale slave response; it is never routed to a master.
        m_bready  = 1'b1;
        m_rready  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (arb_found) begin
          gidx_d           = arb_idx;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          state_d          = arb_wr ? S_WADDR : S_RADDR;
        end
      end

      S_WADDR: begin
        // AW and W complete independently; the done flags stop re-issuing either.
        m_awvalid          = s_awvalid[gidx_q] & ~aw_done_q;
        m_wvalid           = s_wvalid[gidx_q] & ~w_done_q;
        s_awready[gidx_q]  = m_awready & ~aw_done_q;
        s_wready[gidx_q]   = m_wready & ~w_done_q;
        aw_hs              = m_awvalid & m_awready;
        w_hs               = m_wvalid & m_wready;
        aw_done_d          = aw_done_q | aw_hs;
        w_done_d           = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = S_WRESP;
          tcnt_d  = '0;
        end
      end

      S_WRESP: begin
        if (err_pend) begin
          s_bvalid[gidx_q]       = 1'b1;
          s_bresp[gidx_q*2 +: 2] = 2'b10;
          m_bready               = 1'b1;
          if (s_bready[gidx_q]) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_next;
            grant_d  = '0;
            if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'd1;
          end
        end else begin
          s_bvalid[gidx_q]       = m_bvalid;
          s_bresp[gidx_q*2 +: 2] = m_bresp;
          m_bready               = s_bready[gidx_q];
          if (m_bvalid && s_bready[gidx_q]) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_next;
            grant_d  = '0;
          end else if (!m_bvalid && (TO_LIM != 32'd0)) begin
            tcnt_d = tcnt_q + 32'd1;
          end
        end
      end

      S_RADDR: begin
        m_arvalid         = s_arvalid[gidx_q];
        s_arready[gidx_q] = m_arready;
        if (m_arvalid && m_arready) begin
          state_d = S_RDATA;
          tcnt_d  = '0;
        end
      end

      S_RDATA: begin
        if (err_pend) begin
          s_rvalid[gidx_q]          = 1'b1;
          s_rresp[gidx_q*2 +: 2]    = 2'b10;
          s_rdata[gidx_q*DW +: DW]  = ERRDATA;
          m_rready                  = 1'b1;
          if (s_rready[gidx_q]) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_next;
            grant_d  = '0;
            if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'd1;
          end
        end else begin
          s_rvalid[gidx_q]          = m_rvalid;
          s_rresp[gidx_q*2 +: 2]    = m_rresp;
          s_rdata[gidx_q*DW +: DW]  = m_rdata;
          m_rready                  = s_rready[gidx_q];
          if (m_rvalid && s_rready[gidx_q]) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_next;
            grant_d  = '0;
          end else if (!m_rvalid && (TO_LIM != 32'd0)) begin
            tcnt_d = tcnt_q + 32'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gidx_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      tcnt_q    <= '0;
      tocnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      tcnt_q    <= tcnt_d;
      tocnt_q   <= tocnt_d;
    end
  end

endmodule

// File: tb/tb_axil_bram_arbiter.sv
// tb/tb_axil_bram_arbiter.sv - directed self-checking bench for axil_bram_arbiter
module tb_axil_bram_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              sclk = 1'b0;
  logic              reset = 1'b1;
  logic [NM*AW-1:0]  s_awaddr = '0;
  logic [NM-1:0]     s_awvalid = '0;
  logic [NM-1:0]     s_awready;
  logic [NM*DW-1:0]  s_wdata = '0;
  logic [NM*4-1:0]   s_wstrb = '0;
  logic [NM-1:0]     s_wvalid = '0;
  logic [NM-1:0]     s_wready;
  logic [NM*2-1:0]   s_bresp;
  logic [NM-1:0]     s_bvalid;
  logic [NM-1:0]     s_bready = '0;
  logic [NM*AW-1:0]  s_araddr = '0;
  logic [NM-1:0]     s_arvalid = '0;
  logic [NM-1:0]     s_arready;
  logic [NM*DW-1:0]  s_rdata;
  logic [NM*2-1:0]   s_rresp;
  logic [NM-1:0]     s_rvalid;
  logic [NM-1:0]     s_rready = '0;
  logic [AW-1:0]     m_awaddr;
  logic              m_awvalid;
  logic              m_awready = 1'b1;
  logic [DW-1:0]     m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready = 1'b1;
  logic [1:0]        m_bresp = 2'b00;
  logic              m_bvalid = 1'b0;
  logic              m_bready;
  logic [AW-1:0]     m_araddr;
  logic              m_arvalid;
  logic              m_arready = 1'b1;
  logic [DW-1:0]     m_rdata = '0;
  logic [1:0]        m_rresp = 2'b00;
  logic              m_rvalid = 1'b0;
  logic              m_rready;
  logic [NM-1:0]     grant;
  logic              busy;
  logic [15:0]       timeout_cnt;

  axil_bram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(16), .ERRDATA(32'hDEADBEEF)) dut (
    .sclk(sclk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 sclk = ~sclk;

  // BRAM slave model
  logic [31:0] mem [0:63];
  logic [31:0] sl_awaddr = '0;
  logic [31:0] sl_wdata = '0;
  logic        aw_have = 1'b0;
  logic        w_have = 1'b0;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  logic        no_rvalid = 1'b0;
  logic        no_bvalid = 1'b0;
  logic        inject_r = 1'b0;

  always @(posedge sclk) begin
    if (m_awvalid && m_awready) begin
      aw_cnt    <= aw_cnt + 1;
      sl_awaddr <= m_awaddr;
      aw_have   <= 1'b1;
    end
    if (m_wvalid && m_wready) begin
      w_cnt    <= w_cnt + 1;
      sl_wdata <= m_wdata;
      w_have   <= 1'b1;
    end
    if (m_bvalid && m_bready) m_bvalid <= 1'b0;
    if (aw_have && w_have && !m_bvalid && !no_bvalid) begin
      mem[sl_awaddr[7:2]] <= sl_wdata;
      m_bvalid <= 1'b1;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
    end
    if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    if (m_arvalid && m_arready && !no_rvalid) begin
      m_rvalid <= 1'b1;
      m_rdata  <= mem[m_araddr[7:2]];
    end
    if (inject_r) begin
      m_rvalid <= 1'b1;
      m_rdata  <= 32'h12345678;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0]    r_bresp, r_rresp;
  logic [31:0]   r_rdata;
  logic [NM-1:0] r_grant;
  int            r_bcyc, r_rcyc, r_awcyc, r_wcyc, r_dupaw;

  // One master transaction: optional write (AW+W together) and/or read on the same address.
  task automatic mxfer(input int i, input bit dw, input bit dr, input logic [31:0] a,
                       input logic [31:0] d, input int wdel, input string tag);
    bit awhs, whs, arhs, bhs, rhs, awdone, bdone, rdone;
    int cyc;
    s_awaddr[i*AW +: AW] = a;
    s_araddr[i*AW +: AW] = a;
    s_wdata[i*DW +: DW]  = d;
    s_wstrb[i*4 +: 4]    = 4'hF;
    s_awvalid[i] = dw;
    s_wvalid[i]  = dw;
    s_arvalid[i] = dr;
    s_bready[i]  = 1'b1;
    s_rready[i]  = 1'b1;
    if (wdel > 0) m_wready = 1'b0;
    awdone = !dw; bdone = !dw; rdone = !dr;
    cyc = 0; r_bcyc = -1; r_rcyc = -1; r_awcyc = -1; r_wcyc = -1; r_dupaw = 0;
    r_grant = '0;
    while (!(bdone && rdone) && cyc < 300) begin
      #1;
      if (awdone && m_awvalid) r_dupaw++;
      awhs = s_awvalid[i] & s_awready[i];
      whs  = s_wvalid[i] & s_wready[i];
      arhs = s_arvalid[i] & s_arready[i];
      bhs  = s_bvalid[i] & s_bready[i];
      rhs  = s_rvalid[i] & s_rready[i];
      if (awhs) r_awcyc = cyc;
      if (whs) r_wcyc = cyc;
      if (bhs) begin r_bresp = s_bresp[i*2 +: 2]; r_bcyc = cyc; r_grant = grant; end
      if (rhs) begin
        r_rdata = s_rdata[i*DW +: DW]; r_rresp = s_rresp[i*2 +: 2]; r_rcyc = cyc;
        if (!dw) r_grant = grant;
      end
      @(negedge sclk);
      cyc++;
      if (awhs) begin s_awvalid[i] = 1'b0; awdone = 1'b1; end
      if (whs) s_wvalid[i] = 1'b0;
      if (arhs) s_arvalid[i] = 1'b0;
      if (bhs) bdone = 1'b1;
      if (rhs) rdone = 1'b1;
      if (wdel > 0 && r_awcyc >= 0 && (cyc - r_awcyc) >= wdel) m_wready = 1'b1;
    end
    chk({tag, "_completed"}, {31'd0, bdone && rdone}, 32'd1);
    s_bready[i] = 1'b0;
    s_rready[i] = 1'b0;
    s_awvalid[i] = 1'b0; s_wvalid[i] = 1'b0; s_arvalid[i] = 1'b0;
    m_wready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int aw0, w0, n;
  int seq_m [0:3];
  logic [31:0] seq_d [0:3];

  initial begin
    // Reset state
    @(negedge sclk);
    @(negedge sclk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_m_bready", {31'd0, m_bready}, 32'd1);
    chk("rst_m_rready", {31'd0, m_rready}, 32'd1);
    chk("rst_timeout_cnt", {16'd0, timeout_cnt}, 32'd0);
    chk("rst_m_awvalid", {31'd0, m_awvalid}, 32'd0);
    @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);

    // 1: M0 write
    aw0 = aw_cnt; w0 = w_cnt;
    mxfer(0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 0, "t1");
    chk("t1_aw_count", aw_cnt - aw0, 32'd1);
    chk("t1_w_count", w_cnt - w0, 32'd1);
    chk("t1_bresp", {30'd0, r_bresp}, 32'd0);
    chk("t1_grant", {30'd0, r_grant}, 32'd1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // M1 write for the alternating-read test
    mxfer(1, 1'b1, 1'b0, 32'h14, 32'h5A5A0001, 0, "pre2");
    chk("pre2_grant", {30'd0, r_grant}, 32'd2);

    // 2: continuous reads from both masters alternate M0,M1,M0,M1
    s_araddr[0 +: AW]  = 32'h10;
    s_araddr[AW +: AW] = 32'h14;
    s_arvalid = 2'b11;
    s_rready  = 2'b11;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      #1;
      for (int i = 0; i < NM; i++) begin
        if (s_rvalid[i] && s_rready[i] && n < 4) begin
          seq_m[n] = i;
          seq_d[n] = s_rdata[i*DW +: DW];
          n++;
        end
      end
      @(negedge sclk);
    end
    s_arvalid = 2'b00;
    s_rready  = 2'b00;
    chk("t2_resp_count", n, 32'd4);
    chk("t2_order0", seq_m[0], 32'd0);
    chk("t2_order1", seq_m[1], 32'd1);
    chk("t2_order2", seq_m[2], 32'd0);
    chk("t2_order3", seq_m[3], 32'd1);
    chk("t2_data0", seq_d[0], 32'hA5A5A5A5);
    chk("t2_data1", seq_d[1], 32'h5A5A0001);
    chk("t2_data3", seq_d[3], 32'h5A5A0001);
    @(negedge sclk);

    // 3: M1 AW+W and AR together on 0x20
    mxfer(1, 1'b1, 1'b1, 32'h20, 32'hC0FFEE01, 0, "t3");
    chk("t3_write_first", {31'd0, (r_bcyc >= 0) && (r_bcyc < r_rcyc)}, 32'd1);
    chk("t3_bresp", {30'd0, r_bresp}, 32'd0);
    chk("t3_rdata", r_rdata, 32'hC0FFEE01);
    chk("t3_rresp", {30'd0, r_rresp}, 32'd0);
    chk("t3_grant", {30'd0, r_grant}, 32'd2);

    // 4: wready delayed 5 cycles after awready
    aw0 = aw_cnt; w0 = w_cnt;
    mxfer(0, 1'b1, 1'b0, 32'h30, 32'h11223344, 5, "t4");
    chk("t4_aw_count", aw_cnt - aw0, 32'd1);
    chk("t4_w_count", w_cnt - w0, 32'd1);
    chk("t4_dup_awvalid", r_dupaw, 32'd0);
    chk("t4_w_delay", r_wcyc - r_awcyc, 32'd5);
    chk("t4_resp_after_w", {31'd0, r_bcyc > r_wcyc}, 32'd1);
    chk("t4_bresp", {30'd0, r_bresp}, 32'd0);

    // 5: read timeout, slave never answers
    no_rvalid = 1'b1;
    mxfer(0, 1'b0, 1'b1, 32'h10, 32'h0, 0, "t5");
    no_rvalid = 1'b0;
    chk("t5_rresp", {30'd0, r_rresp}, 32'd2);
    chk("t5_rdata", r_rdata, 32'hDEADBEEF);
    chk("t5_latency", r_rcyc, 32'd18);
    chk("t5_timeout_cnt", {16'd0, timeout_cnt}, 32'd1);
    inject_r = 1'b1;
    @(negedge sclk);
    inject_r = 1'b0;
    #1;
    chk("t5_late_not_routed", {30'd0, s_rvalid}, 32'd0);
    chk("t5_late_absorbed", {31'd0, m_rready}, 32'd1);
    @(negedge sclk);
    chk("t5_idle_after", {31'd0, busy}, 32'd0);

    // 6: reset during WRESP, then a fresh write
    no_bvalid = 1'b1;
    s_awaddr[0 +: AW] = 32'h44;
    s_wdata[0 +: DW]  = 32'h00000099;
    s_wstrb[0 +: 4]   = 4'hF;
    s_awvalid[0] = 1'b1;
    s_wvalid[0]  = 1'b1;
    s_bready[0]  = 1'b1;
    @(negedge sclk);
    @(negedge sclk);
    s_awvalid[0] = 1'b0;
    s_wvalid[0]  = 1'b0;
    #1;
    chk("t6_busy_wresp", {31'd0, busy}, 32'd1);
    chk("t6_grant_wresp", {30'd0, grant}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy_reset", {31'd0, busy}, 32'd0);
    chk("t6_grant_reset", {30'd0, grant}, 32'd0);
    chk("t6_bready_reset", {31'd0, m_bready}, 32'd1);
    chk("t6_tocnt_reset", {16'd0, timeout_cnt}, 32'd0);
    @(negedge sclk);
    reset = 1'b0;
    no_bvalid = 1'b0;
    s_bready[0] = 1'b0;
    repeat (3) @(negedge sclk);
    #1;
    chk("t6_stale_not_routed", {30'd0, s_bvalid}, 32'd0);
    @(negedge sclk);
    mxfer(0, 1'b1, 1'b0, 32'h40, 32'h0BADF00D, 0, "t6w");
    chk("t6_bresp", {30'd0, r_bresp}, 32'd0);
    chk("t6_grant", {30'd0, r_grant}, 32'd1);
    mxfer(0, 1'b0, 1'b1, 32'h40, 32'h0, 0, "t6r");
    chk("t6_readback", r_rdata, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
